low_synth: RTL and testbench

- Wavelet synthesis low-pass branch: upsample-by-2 interpolator with an 8-tap FIR, computed in polyphase form.
- Each accepted 16-bit approximation sample produces two 28-bit output samples, even phase first, then odd phase.
- Uses one time-multiplexed multiplier/accumulator (MAC): 4 taps per phase, 4 clocks per phase.
- Sits after the decomposition low branch's data_out/data_out_flag stream (after any rescaling to 16 bits) and feeds the reconstruction adder.

---
 rtl/low_synth_pkg.sv | 16 +
 rtl/low_synth_mac.sv | 23 ++
 rtl/low_synth.sv | 87 ++++++++
 tb/tb_low_synth.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/low_synth_pkg.sv
// low_synth_pkg: shared widths, FSM encoding and synthesis low-pass coefficients.
package low_synth_pkg;
  localparam int DW_DEF = 16;
  localparam int CW_DEF = 9;
  localparam int OW_DEF = 28;
  localparam int ACCW_DEF = DW_DEF + CW_DEF + 2;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t MAC_E = 3'd1;
  localparam state_t OUT_E = 3'd2;
  localparam state_t MAC_O = 3'd3;
  localparam state_t OUT_O = 3'd4;
  localparam logic signed [CW_DEF-1:0] H [0:7] = '{
    9'sd59, 9'sd183, 9'sd162, -9'sd7, -9'sd48, 9'sd8, 9'sd8, -9'sd3
  };
endpackage

// File: rtl/low_synth_mac.sv
// low_synth_mac: registered signed multiply-accumulate with synchronous clear and enable.
module low_synth_mac #(
  parameter int DW   = 16,
  parameter int CW   = 9,
  parameter int ACCW = DW + CW + 2
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [CW-1:0]   b_i,
  output logic signed [ACCW-1:0] acc_o
);
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  assign prod = a_i * b_i;
  always_comb acc_d = clr_i ? '0 : en_i ? acc_q + ACCW'(prod) : acc_q;
  always_ff @(posedge clk or negedge reset_ni)
    if (!reset_ni) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/low_synth.sv
// low_synth: polyphase upsample-by-2 8-tap FIR, one shared MAC, two outputs per input.
// Define LOW_SYNTH_OVR_EN to add the sticky ovr flag for samples dropped while busy.
module low_synth
  import low_synth_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef LOW_SYNTH_OVR_EN
  input  logic                 ovr_clr,
  output logic                 ovr,
`else
  // without the flag, overrun samples vanish silently
`endif
  input  logic signed [DW-1:0] data_in,
  input  logic                 data_in_ready,
  output logic signed [OW-1:0] data_out,
  output logic                 data_out_flag,
  output logic                 busy
);
  localparam int ACCW = DW + CW + 2;
  state_t                 state_q, state_d;
  logic [1:0]             tap_q, tap_d;
  logic signed [DW-1:0]   x_q [0:3];
  logic signed [DW-1:0]   x_d [0:3];
  logic signed [OW-1:0]   data_out_q, data_out_d;
  logic                   flag_d, flag_q, accept, mac_en;
  logic signed [ACCW-1:0] acc;
  logic signed [CW-1:0]   coef;
  assign accept = data_in_ready && state_q == IDLE;
  assign mac_en = state_q == MAC_E || state_q == MAC_O;
  assign coef   = CW'(H[{tap_q, state_q == MAC_O}]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = data_in_ready ? MAC_E : IDLE;
      MAC_E:   state_d = tap_q == 2'd3 ? OUT_E : MAC_E;
      OUT_E:   state_d = MAC_O;
      MAC_O:   state_d = tap_q == 2'd3 ? OUT_O : MAC_O;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tap_d      = mac_en ? tap_q + 2'd1 : 2'd0;
    flag_d     = state_q == OUT_E || state_q == OUT_O;
    data_out_d = flag_d ? OW'(acc) : data_out_q;
    x_d        = accept ? '{data_in, x_q[0], x_q[1], x_q[2]} : x_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      x_q        <= '{default: '0};
      data_out_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      x_q        <= x_d;
      data_out_q <= data_out_d;
      flag_q     <= flag_d;
    end
  // the accumulator restarts on acceptance and again after the even result is taken
  low_synth_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
    .clk      (clk),
    .reset_ni (reset),
    .clr_i    (accept || state_q == OUT_E),
    .en_i     (mac_en),
    .a_i      (x_q[tap_q]),
    .b_i      (coef),
    .acc_o    (acc)
  );
  assign data_out      = data_out_q;
  assign data_out_flag = flag_q;
  assign busy          = state_q != IDLE;
`ifdef LOW_SYNTH_OVR_EN
  logic ovr_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovr_q <= 1'b0;
    else ovr_q <= (data_in_ready && busy) ? 1'b1 : ovr_clr ? 1'b0 : ovr_q;
  assign ovr = ovr_q;
`else
`endif
endmodule

// File: tb/tb_low_synth.sv
// tb_low_synth: scoreboard bench for low_synth; expected output pairs are queued at issue.
module tb_low_synth;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic data_in_ready = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [27:0] data_out;
  logic data_out_flag, busy;
`ifdef LOW_SYNTH_OVR_EN
  logic ovr;
  logic ovr_clr = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  logic signed [27:0] exp_q [$];

  low_synth dut (
    .clk           (clk),
    .reset         (reset),
`ifdef LOW_SYNTH_OVR_EN
    .ovr_clr       (ovr_clr),
    .ovr           (ovr),
`endif
    .data_in       (data_in),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_flag (data_out_flag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (data_out_flag !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_flag: got flag=%b data_out=%0d expected no flag", data_out_flag, data_out);
      end else chk("data_out", data_out, exp_q.pop_front());
    end

  task automatic send(input logic signed [15:0] v, input logic signed [27:0] e, input logic signed [27:0] o);
    exp_q.push_back(e);
    exp_q.push_back(o);
    @(negedge clk);
    data_in = v;
    data_in_ready = 1'b1;
    @(negedge clk);
    data_in_ready = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_data_out", data_out, 0);
      chk("idle_busy", busy, 0);
`ifdef LOW_SYNTH_OVR_EN
      chk("idle_ovr", ovr, 0);
`endif
    end
    // impulse response, then silence
    send(100, 5900, 18300);
    send(0, 16200, -700);
    send(0, -4800, 800);
    send(0, 800, -300);
    send(0, 0, 0);
    // step of 1000 ramps through partial sums to 181*1000 in both phases
    do_reset();
    send(1000, 59000, 183000);
    send(1000, 221000, 176000);
    send(1000, 173000, 184000);
    send(1000, 181000, 181000);
    // negative full scale, exercises sign extension to 28 bits
    do_reset();
    send(-32768, -1933312, -5996544);
    send(-32768, -7241728, -5767168);
    send(-32768, -5668864, -6029312);
    send(-32768, -5931008, -5931008);
    // samples offered at T3 and T10 (OUT_O) must be dropped
    do_reset();
    exp_q.push_back(5900);
    exp_q.push_back(18300);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      data_in_ready = (c == 0 || c == 3 || c == 10);
      data_in = (c == 0) ? 16'sd100 : 16'sd7000;
      if (c == 2) chk("busy_mid", busy, 1);
      if (c == 10) chk("busy_out_o", busy, 1);
      if (c == 11) chk("busy_done", busy, 0);
`ifdef LOW_SYNTH_OVR_EN
      if (c == 6) chk("ovr_set", ovr, 1);
      ovr_clr = (c == 7);
      if (c == 8) chk("ovr_cleared", ovr, 0);
      if (c == 11) chk("ovr_reset_at_out_o", ovr, 1);
`endif
    end
    send(0, 16200, -700);
    // reset at T7 abandons the odd output
    do_reset();
    exp_q.push_back(5900);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      data_in_ready = (c == 0);
      data_in = 16'sd100;
      if (c == 7) reset = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_flag", data_out_flag, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    send(100, 5900, 18300);
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
